// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed display scanner.
package display_pkg;

   // Polarity selectors for the anode and segment drivers.
   localparam bit POL_ACTIVE_HIGH = 1'b0;
   localparam bit POL_ACTIVE_LOW  = 1'b1;

   // Default timing: 50000 clk cycles per digit slot, 2 cycles of anode dead time.
   localparam int DEF_PRESCALE  = 50000;
   localparam int DEF_GHOST_CYC = 2;

   // Width of an index or counter that must hold values 0..n-1 (never below 1 bit).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..PRESCALE-1 and flags the last cycle of each slot.
module scan_prescaler
   import display_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int CNT_W    = idx_width(PRESCALE)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] count,
   output logic             tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: wrap to zero on the last cycle of the slot.
   always_comb begin
      count_d = count_q + 1'b1;
      if (count_q == LAST_CNT) begin
         count_d = '0;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tick  = (count_q == LAST_CNT);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scanner with tear-free pattern updates,
// anode dead time against ghosting, per-digit enables and global blanking.
//
// load is a one-cycle strobe with no ready: seg_in is captured on every
// clock edge where load=1, the newest capture wins, and it reaches the
// display only at the next frame wrap so a frame never mixes old and new digits.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SEG_W          = 7,
   parameter int PRESCALE       = DEF_PRESCALE,
   parameter int GHOST_CYC      = DEF_GHOST_CYC,
   parameter bit AN_ACTIVE_LOW  = POL_ACTIVE_LOW,
   parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_LOW
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_DIGITS*SEG_W-1:0]        seg_in,
   input  logic                               load,
   input  logic [NUM_DIGITS-1:0]              digit_en,
   input  logic                               blank,
   output logic [SEG_W-1:0]                   seg_out,
   output logic [NUM_DIGITS-1:0]              an,
   output logic [idx_width(NUM_DIGITS)-1:0]   digit_idx,
   output logic                               frame_start
);

   localparam int IDX_W  = idx_width(NUM_DIGITS);
   localparam int CNT_W  = idx_width(PRESCALE);
   localparam int DATA_W = NUM_DIGITS * SEG_W;

   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]      GHOST_CNT = CNT_W'(GHOST_CYC);
   // Inactive level of each output bus; XOR with it converts active-high to pin polarity.
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};
   localparam logic [SEG_W-1:0]      SEG_OFF   = {SEG_W{SEG_ACTIVE_LOW}};

   logic [CNT_W-1:0] presc_cnt;
   logic             presc_tick;
   logic             wrap;

   logic [IDX_W-1:0]      idx_q,     idx_d;
   logic                  fs_q,      fs_d;
   logic [DATA_W-1:0]     staging_q, staging_d;
   logic [DATA_W-1:0]     shadow_q,  shadow_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] an_q,      an_d;
   logic [SEG_W-1:0]      seg_q,     seg_d;

   logic                  lit;
   logic [NUM_DIGITS-1:0] an_raw;
   logic [SEG_W-1:0]      seg_raw;

   scan_prescaler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .count (presc_cnt),
      .tick  (presc_tick)
   );

   // The frame wraps on the last prescaler cycle of the last digit slot.
   assign wrap = presc_tick && (idx_q == LAST_IDX);

   // Slot index advances once per prescaler period; frame_start marks the cycle after the wrap.
   always_comb begin
      idx_d = idx_q;
      if (presc_tick) begin
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      fs_d = wrap;
   end

   // Staging/shadow update: loads land in staging; the shadow changes only at the wrap.
   always_comb begin
      staging_d = staging_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      if (load) begin
         staging_d = seg_in;
         pending_d = 1'b1;
      end
      if (wrap) begin
         if (load) begin
            shadow_d = seg_in;
         end else if (pending_q) begin
            shadow_d = staging_q;
         end
         pending_d = 1'b0;
      end
   end

   // Output decode: light the current digit after the dead time if enabled and not blanked.
   always_comb begin
      lit     = (presc_cnt >= GHOST_CNT) && digit_en[idx_q] && !blank;
      an_raw  = '0;
      seg_raw = '0;
      if (lit) begin
         an_raw[idx_q] = 1'b1;
         seg_raw       = shadow_q[idx_q*SEG_W +: SEG_W];
      end
      an_d  = an_raw ^ AN_OFF;
      seg_d = seg_raw ^ SEG_OFF;
   end

   // State and output registers; reset drops any pending load and darkens the display.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q     <= '0;
         fs_q      <= 1'b0;
         staging_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_OFF;
      end else begin
         idx_q     <= idx_d;
         fs_q      <= fs_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign seg_out     = seg_q;
   assign an          = an_q;
   assign digit_idx   = idx_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with 4 digits, 7 segments, PRESCALE=4,
// GHOST_CYC=1 and active-low anodes and segments.
module tb_display_scan_mux;

   logic        clk;
   logic        reset;
   logic [27:0] seg_in;
   logic        load;
   logic [3:0]  digit_en;
   logic        blank;
   logic [6:0]  seg_out;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        frame_start;

   int errors = 0;
   int checks = 0;
   int n      = 0;          // clock edges since the last reset edge
   logic [6:0] sh_exp[4];   // pattern the display is expected to show per digit

   display_scan_mux #(
      .NUM_DIGITS     (4),
      .SEG_W          (7),
      .PRESCALE       (4),
      .GHOST_CYC      (1),
      .AN_ACTIVE_LOW  (1'b1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .seg_in      (seg_in),
      .load        (load),
      .digit_en    (digit_en),
      .blank       (blank),
      .seg_out     (seg_out),
      .an          (an),
      .digit_idx   (digit_idx),
      .frame_start (frame_start)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [27:0] pack(input logic [6:0] d0, input logic [6:0] d1,
                                        input logic [6:0] d2, input logic [6:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   // One clock, then compare every output against the scan schedule.
   // Outputs at cycle n reflect the counter/index state of cycle n-1.
   task automatic step_check();
      logic [3:0] en_s;
      logic       bl_s;
      logic [3:0] oh;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      int m, c, d;
      bit act;
      en_s = digit_en;
      bl_s = blank;
      @(posedge clk);
      #1;
      n++;
      m   = n - 1;
      c   = m % 4;
      d   = (m / 4) % 4;
      act = (c >= 1) && en_s[d] && !bl_s;
      oh  = 4'b0001 << d;
      exp_an  = act ? ~oh : 4'hF;
      exp_seg = act ? (7'h7F & ~sh_exp[d]) : 7'h7F;
      check("an", 32'(an), 32'(exp_an));
      check("seg_out", 32'(seg_out), 32'(exp_seg));
      check("digit_idx", 32'(digit_idx), 32'((n / 4) % 4));
      check("frame_start", 32'(frame_start), 32'(n % 16 == 0));
   endtask

   task automatic run_to(input int target);
      while (n < target) step_check();
   endtask

   task automatic reset_outputs_check(input string tag);
      check({tag, "_an"}, 32'(an), 32'h0000_000F);
      check({tag, "_seg"}, 32'(seg_out), 32'h0000_007F);
      check({tag, "_idx"}, 32'(digit_idx), 32'd0);
      check({tag, "_fs"}, 32'(frame_start), 32'd0);
   endtask

   initial begin
      logic [3:0] an_tbl[16];
      int lows[4];

      reset    = 1'b1;
      load     = 1'b0;
      seg_in   = '0;
      digit_en = 4'hF;
      blank    = 1'b0;
      for (int i = 0; i < 4; i++) sh_exp[i] = 7'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset_outputs_check("reset");
      reset = 1'b0;
      n     = 0;

      // First frame scan, hand table of anode values for cycles 1..16
      an_tbl = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
      for (int i = 0; i < 16; i++) begin
         step_check();
         check("scan_table_an", 32'(an), 32'(an_tbl[i]));
      end
      // Second frame: each anode low for 3 of its 4 slot cycles
      for (int i = 0; i < 4; i++) lows[i] = 0;
      for (int i = 0; i < 16; i++) begin
         step_check();
         for (int b = 0; b < 4; b++) if (an[b] == 1'b0) lows[b]++;
      end
      for (int b = 0; b < 4; b++) check("duty_lows", 32'(lows[b]), 32'd3);

      // Mid-frame load: invisible until the next wrap, then 7'h40 on digit 0
      run_to(36);
      load   = 1'b1;
      seg_in = pack(7'h3F, 7'h00, 7'h00, 7'h00);
      step_check();
      load   = 1'b0;
      seg_in = 28'($urandom());
      run_to(48);
      sh_exp[0] = 7'h3F;
      run_to(50);
      check("load_mid_seg", 32'(seg_out), 32'h40);
      run_to(52);

      // Two loads in one frame: only the last survives
      load   = 1'b1;
      seg_in = pack(7'h06, 7'h00, 7'h00, 7'h00);
      step_check();
      load   = 1'b0;
      seg_in = 28'($urandom());
      run_to(55);
      load   = 1'b1;
      seg_in = pack(7'h5B, 7'h00, 7'h00, 7'h00);
      step_check();
      load   = 1'b0;
      seg_in = 28'($urandom());
      run_to(64);
      sh_exp[0] = 7'h5B;
      run_to(66);
      check("last_load_seg", 32'(seg_out), 32'h24);
      // A further wrap with nothing pending leaves the pattern alone
      run_to(82);
      check("no_pending_seg", 32'(seg_out), 32'h24);

      // Load coincident with the wrap edge shows in the very next digit-0 slot
      run_to(95);
      load   = 1'b1;
      seg_in = pack(7'h66, 7'h4F, 7'h00, 7'h00);
      step_check();
      load   = 1'b0;
      seg_in = 28'($urandom());
      sh_exp[0] = 7'h66;
      sh_exp[1] = 7'h4F;
      run_to(98);
      check("wrap_load_d0", 32'(seg_out), 32'h19);
      run_to(102);
      check("wrap_load_d1", 32'(seg_out), 32'h30);

      // Digit 2 disabled, plus a 5-cycle blank pulse
      run_to(104);
      digit_en = 4'b1011;
      while (n < 110) begin
         step_check();
         check("disabled_an2", 32'(an[2]), 32'd1);
      end
      blank = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step_check();
         check("blank_an", 32'(an), 32'hF);
         check("blank_seg", 32'(seg_out), 32'h7F);
      end
      blank = 1'b0;
      while (n < 128) begin
         step_check();
         check("disabled_an2", 32'(an[2]), 32'd1);
      end
      digit_en = 4'hF;

      // Reset mid-frame with a load pending and a load coincident with reset
      run_to(132);
      load   = 1'b1;
      seg_in = pack(7'h00, 7'h00, 7'h7F, 7'h00);
      step_check();
      load = 1'b0;
      run_to(137);
      reset  = 1'b1;
      load   = 1'b1;
      seg_in = pack(7'h7F, 7'h7F, 7'h7F, 7'h7F);
      @(posedge clk);
      #1;
      reset_outputs_check("mid_reset");
      reset  = 1'b0;
      load   = 1'b0;
      seg_in = '0;
      n      = 0;
      for (int i = 0; i < 4; i++) sh_exp[i] = 7'h00;
      // Neither the discarded pending pattern nor the reset-time load may appear
      run_to(36);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SEG_W, default 7: segment lines per digit.
REQ-003 SHALL have parameter PRESCALE, default 50000: clk cycles per digit slot (>=2).
REQ-004 SHALL have parameter GHOST_CYC, default 2: anode-off dead time at slot start (0..PRESCALE-1).
REQ-005 SHALL have parameter AN_ACTIVE_LOW, default 1: 1 means anodes are driven low to enable.
REQ-006 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means seg_out is inverted from seg_in encoding.
REQ-007 SHALL have clk, input, 1: the single clock; all logic on posedge.
REQ-008 SHALL have reset, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have seg_in, input, NUM_DIGITS*SEG_W: digit patterns, digit 0 in LSBs, 1 = segment lit.
REQ-010 SHALL have load, input, 1: one-cycle request to capture seg_in.
REQ-011 SHALL have digit_en, input, NUM_DIGITS: per-digit enable; 0 keeps that anode inactive.
REQ-012 SHALL have blank, input, 1: forces all anodes inactive while high.
REQ-013 SHALL have seg_out, output, SEG_W: registered segment drive.
REQ-014 SHALL have an, output, NUM_DIGITS: registered one-hot anode drive.
REQ-015 SHALL have digit_idx, output, clog2(NUM_DIGITS): current slot index.
REQ-016 SHALL have frame_start, output, 1: one-cycle pulse when digit_idx wraps to 0.

Function
REQ-017 Prescaler SHALL count 0..PRESCALE-1; at PRESCALE-1 it wraps to 0 and digit_idx advances on the same edge.
REQ-018 digit_idx SHALL wrap from NUM_DIGITS-1 to 0, and frame_start SHALL be 1 for exactly the cycle after that edge.
REQ-019 load SHALL copy seg_in into a staging register and set pending; seg_in SHALL be ignored when load is 0.
REQ-020 At each wrap edge, the shadow register SHALL take seg_in if load is high that cycle, else staging if pending; pending SHALL then clear (tear-free update).
REQ-021 Repeated loads within one frame SHALL keep only the last one.
REQ-022 an SHALL be the one-hot of digit_idx only when the prescaler count >= GHOST_CYC, digit_en[digit_idx]=1 and blank=0; otherwise all anodes SHALL be inactive.
REQ-023 seg_out SHALL show the shadow pattern for digit_idx when that digit's anode is active, else all segments inactive.
REQ-024 an and seg_out SHALL be registered with one cycle of latency from the counter/index state.
REQ-025 Polarity SHALL be applied at the output register only, per AN_ACTIVE_LOW and SEG_ACTIVE_LOW.
REQ-026 Disabled digits SHALL keep their slot, so per-digit duty stays constant regardless of digit_en.
REQ-027 blank SHALL NOT stop the prescaler, the index or the load logic.

Reset
REQ-028 With reset high at a posedge: prescaler, digit_idx, staging, shadow and pending SHALL be 0, frame_start 0, and an/seg_out all inactive (polarity-correct).
REQ-029 reset SHALL dominate load, and a pending update SHALL be discarded if reset arrives mid-frame.
REQ-030 The first frame after reset release SHALL start at digit_idx=0, prescaler=0.

Structure
REQ-031 Package display_pkg SHALL hold the polarity constants, the default PRESCALE/GHOST_CYC values and the index-width function.
REQ-032 The prescaler SHALL be a sub-module scan_prescaler (count, tick output); all other logic stays in display_scan_mux.

Verification (NUM_DIGITS=4, SEG_W=7, PRESCALE=4, GHOST_CYC=1, both polarities active-low)
REQ-033 Release reset, all digit_en=1, shadow=0 -> an cycles 1110,1101,1011,0111; each anode is low for 3 of 4 cycles; frame_start pulses every 16 cycles.
REQ-034 load with seg_in digit0=7'h3F mid-frame -> seg_out unchanged until after the next wrap, then 7'h40 during digit-0 slots.
REQ-035 load 7'h06 then 7'h5B in the same frame -> only 7'h5B (out 7'h24) appears; pending clear after the wrap.
REQ-036 load coincident with the wrap edge -> new pattern is visible in the immediately following digit-0 slot.
REQ-037 digit_en=4'b1011, and blank pulsed for 5 cycles -> an[2] never low; all anodes high during blank; digit_idx sequence unaffected.
REQ-038 reset asserted mid-frame with a load pending -> next cycle an=4'hF, seg_out=7'h7F, digit_idx=0; the pending pattern is never displayed.
